mii_rx_deframer: RTL and testbench
==================================

Name: mii_rx_deframer

Overview:
- Consumes the MII receive side (`mac_mii_rxc`, `mac_mii_rxdv`, `mac_mii_rxd`) produced by the SMII/RMII PHY interface blocks.
- Those MII signals are registered outputs in the `phy_smii_ref_clk` domain, so this block samples them synchronously in that domain. It uses `mac_mii_rxc` rising-edge detection as a sample enable.
- It strips preamble/SFD, assembles nibbles into bytes, and emits a byte stream with `last` / `err` / FCS-good flags.
- It keeps saturating good/bad frame counters. It sits between the PHY interface and the user packet logic.

Parameters:
- PRE_MIN, 2, minimum number of 0x5 preamble nibbles required before the SFD nibble 0xD.
- MIN_BYTES, 64, frames shorter than this (post-SFD, FCS included) are flagged runt.
- MAX_BYTES, 1522, frames reaching this byte count are truncated and flagged.

Ports:
- phy_smii_ref_clk  input  1  the single clock, 125MHz.
- rstn_async  input  1  asynchronous active-low reset.
- mac_mii_rxc  input  1  MII rx clock as a data-level signal from the PHY interface.
- mac_mii_rxdv  input  1  MII rx data valid.
- mac_mii_rxd  input  4  MII rx nibble.
- out_valid  output  1  one-cycle strobe, out_data valid.
- out_data  output  8  received byte, first byte = first byte after SFD.
- out_last  output  1  qualifies out_valid: final byte of frame.
- out_err  output  1  qualifies out_last: frame error (bad FCS, odd nibble, runt, truncation, or rxdv not low at truncation).
- out_fcs_ok  output  1  qualifies out_last: CRC residue correct.
- frame_ok_cnt  output  16  count of frames ending with out_err=0; saturates at 0xFFFF.
- frame_err_cnt  output  16  count of frames ending with out_err=1; saturates at 0xFFFF.

Behaviour:
- Reset: all outputs 0, all counters 0, FSM in IDLE, internal byte buffer empty. Reset mid-frame discards the frame with no output. After reset release, the first rxdv=1 sample starts a fresh preamble hunt, and only if the FSM is in IDLE.
- Sample enable: rxc_r <= mac_mii_rxc; smp = mac_mii_rxc & ~rxc_r. rxdv/rxd are sampled only in smp cycles. All outputs are registered and change at most one cycle after smp.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - smp & rxdv & rxd==5 -> PREAMBLE, pre_cnt=1.
  - smp & rxdv & other nibble -> DROP.
- PREAMBLE:
  - rxd==5 -> pre_cnt++ (saturate at 15).
  - rxd==D & pre_cnt>=PRE_MIN -> DATA; clear nibble phase, byte count and CRC (init 0xFFFFFFFF).
  - Any other nibble -> DROP.
  - rxdv=0 -> IDLE with no output.
- DATA, nibble phase:
  - Nibble phase 0 stores the low nibble.
  - Phase 1 forms byte {rxd, low} and feeds it to the reflected CRC-32 (poly 0xEDB88320, LSB first).
  - Each completed byte is held in a one-byte buffer. On completion of the next byte, the buffer is emitted with out_valid=1, out_last=0, and the new byte replaces it. Output latency is one byte.
- DATA, end of frame (smp & rxdv=0):
  - Emit buffered byte with out_valid=1, out_last=1.
  - out_fcs_ok = (crc == 0xDEBB20E3).
  - out_err = ~fcs_ok | (nibble phase==1) | (byte_cnt < MIN_BYTES).
  - Bump the matching counter; go to IDLE.
  - A trailing odd nibble is discarded.
  - rxdv falls with zero buffered bytes: nothing is emitted, frame_err_cnt++, go to IDLE.
- Truncation: when byte_cnt reaches MAX_BYTES, the buffered byte is emitted with out_last=1, out_err=1 and out_fcs_ok=0. Then frame_err_cnt++ and the FSM goes to DROP.
- DROP: ignore data until smp & rxdv=0 -> IDLE. No output, no counter change (except the truncation path above).
- byte_cnt is 11 bits wide and saturates at MAX_BYTES.
- out_last, out_err and out_fcs_ok are 0 whenever out_valid=0.
- Counter saturation holds 0xFFFF and never wraps.
- Speed independent: 10M and 100M differ only in the smp rate.

Test Plan:
- 100M frame: preamble 7x0x55 + 0xD5, 60 payload bytes 0x00..0x3B + correct FCS -> 64 out_valid strobes, bytes in order, last strobe out_last=1, out_fcs_ok=1, out_err=0, frame_ok_cnt=1.
- Same frame with one payload bit flipped -> 64 bytes, last has out_fcs_ok=0, out_err=1, frame_err_cnt=1.
- Same good frame at 10M rxc timing -> identical output sequence; no strobes between smp events.
- Frame with extra nibble after FCS (odd count) -> extra nibble not output, out_fcs_ok=1, out_err=1.
- Preamble error (0x55 0x57 ... ) and separately a 30-byte good-FCS frame -> first yields no output and no counter change; second yields out_err=1 runt, frame_err_cnt++.
- 1600-byte frame -> strobe 1522 has out_last=1, out_err=1, remaining nibbles ignored. Then assert rstn_async low mid-next-frame -> all outputs and counters 0, and the next good frame is received correctly.

Source files
------------

// File: rtl/mii_rx_deframer.sv
// ---------------------------------------------------------------------------
// mii_rx_deframer
//
// Purpose:
//   Turns the MII receive nibble stream (already registered in the
//   phy_smii_ref_clk domain by the SMII/RMII PHY interface) into a byte
//   stream. It strips the preamble/SFD, pairs nibbles into bytes (low nibble
//   first), checks the Ethernet FCS by CRC-32 residue, and flags runt, odd
//   nibble and oversize frames. It also keeps saturating good/bad frame
//   counters.
//
// Ports:
//   phy_smii_ref_clk   in   1   single clock (125 MHz)
//   rstn_async         in   1   asynchronous active-low reset
//   mac_mii_rxc        in   1   MII rx clock, used as a data-level signal
//   mac_mii_rxdv       in   1   MII rx data valid
//   mac_mii_rxd        in   4   MII rx nibble
//   out_valid          out  1   one-cycle strobe, out_data valid
//   out_data           out  8   received byte (first byte after SFD first)
//   out_last           out  1   with out_valid: final byte of the frame
//   out_err            out  1   with out_last: frame error
//   out_fcs_ok         out  1   with out_last: CRC residue correct
//   frame_ok_cnt       out  16  frames ended with out_err=0 (saturating)
//   frame_err_cnt      out  16  frames ended with out_err=1 (saturating)
//   dbg_state          out  2   current FSM state (IDLE/PREAMBLE/DATA/DROP)
//
// Output handshake:
//   out_valid is a single-cycle strobe with no back-pressure; out_data,
//   out_last, out_err and out_fcs_ok are meaningful only while out_valid=1
//   and are driven to 0 otherwise. Every output changes at most one clock
//   after the sample-enable cycle that caused it.
// ---------------------------------------------------------------------------
module mii_rx_deframer #(
    parameter int PRE_MIN   = 2,
    parameter int MIN_BYTES = 64,
    parameter int MAX_BYTES = 1522
) (
    input  logic        phy_smii_ref_clk,
    input  logic        rstn_async,
    input  logic        mac_mii_rxc,
    input  logic        mac_mii_rxdv,
    input  logic [3:0]  mac_mii_rxd,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        out_err,
    output logic        out_fcs_ok,
    output logic [15:0] frame_ok_cnt,
    output logic [15:0] frame_err_cnt,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } state_t;

    localparam logic [3:0]  NIB_PRE     = 4'h5;
    localparam logic [3:0]  NIB_SFD     = 4'hD;
    localparam logic [3:0]  PRE_MIN_N   = 4'(PRE_MIN);
    localparam logic [10:0] MIN_B       = 11'(MIN_BYTES);
    localparam logic [10:0] MAX_B       = 11'(MAX_BYTES);
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    // Register value left behind after running the received FCS through the
    // (non-inverted) CRC register of a good frame.
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c,
                                               input logic [7:0]  d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // ---------------- state -------------------------------------------------
    state_t      state,      state_nxt;
    logic [3:0]  pre_cnt,    pre_cnt_nxt;
    logic        phase,      phase_nxt;
    logic [3:0]  low_nib,    low_nib_nxt;
    logic [10:0] byte_cnt,   byte_cnt_nxt;
    logic [31:0] crc,        crc_nxt;
    logic [7:0]  buf_data,   buf_data_nxt;
    logic        buf_full,   buf_full_nxt;
    logic        rxc_r;

    logic        out_valid_nxt;
    logic [7:0]  out_data_nxt;
    logic        out_last_nxt;
    logic        out_err_nxt;
    logic        out_fcs_ok_nxt;
    logic        ok_inc;
    logic        err_inc;

    logic        smp;
    logic [7:0]  byte_now;
    logic [31:0] crc_now;
    logic        fcs_good;
    logic        end_err;

    // rxc is a plain level from the PHY block; its rising edge marks the
    // cycle where rxdv/rxd are stable and should be taken.
    assign smp      = mac_mii_rxc & ~rxc_r;
    assign byte_now = {mac_mii_rxd, low_nib};
    assign crc_now  = crc32_byte(crc, byte_now);
    assign fcs_good = (crc == CRC_RESIDUE);
    assign end_err  = ~fcs_good | phase | (byte_cnt < MIN_B);

    assign dbg_state = state;

    // ---------------- next state / outputs ----------------------------------
    always_comb begin
        state_nxt      = state;
        pre_cnt_nxt    = pre_cnt;
        phase_nxt      = phase;
        low_nib_nxt    = low_nib;
        byte_cnt_nxt   = byte_cnt;
        crc_nxt        = crc;
        buf_data_nxt   = buf_data;
        buf_full_nxt   = buf_full;
        out_valid_nxt  = 1'b0;
        out_data_nxt   = 8'h00;
        out_last_nxt   = 1'b0;
        out_err_nxt    = 1'b0;
        out_fcs_ok_nxt = 1'b0;
        ok_inc         = 1'b0;
        err_inc        = 1'b0;

        if (smp) begin
            unique case (state)
                IDLE: begin
                    if (mac_mii_rxdv) begin
                        if (mac_mii_rxd == NIB_PRE) begin
                            state_nxt   = PREAMBLE;
                            pre_cnt_nxt = 4'd1;
                        end else begin
                            state_nxt = DROP;
                        end
                    end
                end

                PREAMBLE: begin
                    if (!mac_mii_rxdv) begin
                        state_nxt = IDLE;
                    end else if (mac_mii_rxd == NIB_PRE) begin
                        if (pre_cnt != 4'hF) pre_cnt_nxt = pre_cnt + 4'd1;
                    end else if (mac_mii_rxd == NIB_SFD && pre_cnt >= PRE_MIN_N) begin
                        state_nxt    = DATA;
                        phase_nxt    = 1'b0;
                        byte_cnt_nxt = 11'd0;
                        crc_nxt      = CRC_INIT;
                        buf_full_nxt = 1'b0;
                    end else begin
                        state_nxt = DROP;
                    end
                end

                DATA: begin
                    if (!mac_mii_rxdv) begin
                        // End of frame; a dangling low nibble is simply
                        // dropped and reported through the phase term.
                        state_nxt    = IDLE;
                        buf_full_nxt = 1'b0;
                        if (buf_full) begin
                            out_valid_nxt  = 1'b1;
                            out_data_nxt   = buf_data;
                            out_last_nxt   = 1'b1;
                            out_fcs_ok_nxt = fcs_good;
                            out_err_nxt    = end_err;
                            ok_inc         = ~end_err;
                            err_inc        = end_err;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end else if (byte_cnt == MAX_B) begin
                        // Frame still running after the maximum length:
                        // close it out as errored and ignore the rest.
                        state_nxt     = DROP;
                        buf_full_nxt  = 1'b0;
                        out_valid_nxt = 1'b1;
                        out_data_nxt  = buf_data;
                        out_last_nxt  = 1'b1;
                        out_err_nxt   = 1'b1;
                        err_inc       = 1'b1;
                    end else if (!phase) begin
                        low_nib_nxt = mac_mii_rxd;
                        phase_nxt   = 1'b1;
                    end else begin
                        // Byte complete. The buffer delays output by one byte
                        // so the final byte can carry last/err/fcs_ok.
                        phase_nxt    = 1'b0;
                        crc_nxt      = crc_now;
                        byte_cnt_nxt = byte_cnt + 11'd1;
                        if (buf_full) begin
                            out_valid_nxt = 1'b1;
                            out_data_nxt  = buf_data;
                        end
                        buf_data_nxt = byte_now;
                        buf_full_nxt = 1'b1;
                    end
                end

                DROP: begin
                    if (!mac_mii_rxdv) state_nxt = IDLE;
                end

                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---------------- registers ---------------------------------------------
    always_ff @(posedge phy_smii_ref_clk or negedge rstn_async) begin
        if (!rstn_async) begin
            state         <= IDLE;
            pre_cnt       <= 4'd0;
            phase         <= 1'b0;
            low_nib       <= 4'd0;
            byte_cnt      <= 11'd0;
            crc           <= CRC_INIT;
            buf_data      <= 8'h00;
            buf_full      <= 1'b0;
            rxc_r         <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= 8'h00;
            out_last      <= 1'b0;
            out_err       <= 1'b0;
            out_fcs_ok    <= 1'b0;
            frame_ok_cnt  <= 16'h0000;
            frame_err_cnt <= 16'h0000;
        end else begin
            state      <= state_nxt;
            pre_cnt    <= pre_cnt_nxt;
            phase      <= phase_nxt;
            low_nib    <= low_nib_nxt;
            byte_cnt   <= byte_cnt_nxt;
            crc        <= crc_nxt;
            buf_data   <= buf_data_nxt;
            buf_full   <= buf_full_nxt;
            rxc_r      <= mac_mii_rxc;
            out_valid  <= out_valid_nxt;
            out_data   <= out_data_nxt;
            out_last   <= out_last_nxt;
            out_err    <= out_err_nxt;
            out_fcs_ok <= out_fcs_ok_nxt;
            if (ok_inc && frame_ok_cnt != 16'hFFFF)
                frame_ok_cnt <= frame_ok_cnt + 16'd1;
            if (err_inc && frame_err_cnt != 16'hFFFF)
                frame_err_cnt <= frame_err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mii_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_mii_rx_deframer
//
// Drives MII nibbles at 100M (rxc period 5 clocks) and 10M (50 clocks)
// rates. Each expected output byte {last, err, fcs_ok, data} goes into
// exp_q when a frame is issued; a monitor on the falling clock edge pops
// and compares on every out_valid strobe.
// ---------------------------------------------------------------------------
module tb_mii_rx_deframer;

    localparam int P100 = 5;
    localparam int P10  = 50;

    logic        phy_smii_ref_clk = 1'b0;
    logic        rstn_async       = 1'b0;
    logic        mac_mii_rxc      = 1'b0;
    logic        mac_mii_rxdv     = 1'b0;
    logic [3:0]  mac_mii_rxd      = 4'h0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_err;
    logic        out_fcs_ok;
    logic [15:0] frame_ok_cnt;
    logic [15:0] frame_err_cnt;
    logic [1:0]  dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    logic [10:0] exp_q[$];
    logic [7:0]  frm[$];

    mii_rx_deframer dut (
        .phy_smii_ref_clk (phy_smii_ref_clk),
        .rstn_async       (rstn_async),
        .mac_mii_rxc      (mac_mii_rxc),
        .mac_mii_rxdv     (mac_mii_rxdv),
        .mac_mii_rxd      (mac_mii_rxd),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_last         (out_last),
        .out_err          (out_err),
        .out_fcs_ok       (out_fcs_ok),
        .frame_ok_cnt     (frame_ok_cnt),
        .frame_err_cnt    (frame_err_cnt),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock / reset -----------------------------------------
    always #4 phy_smii_ref_clk = ~phy_smii_ref_clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ------------------------------------------
    // One nibble per rxc period; data changes while rxc is low and the DUT
    // takes it on the rising edge.
    task automatic send_nib(input logic dv, input logic [3:0] d, input int period);
        @(negedge phy_smii_ref_clk);
        mac_mii_rxc  = 1'b0;
        mac_mii_rxdv = dv;
        mac_mii_rxd  = d;
        repeat (period / 2) @(negedge phy_smii_ref_clk);
        mac_mii_rxc = 1'b1;
        repeat (period - period / 2 - 1) @(negedge phy_smii_ref_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int period);
        send_nib(1'b1, b[3:0], period);
        send_nib(1'b1, b[7:4], period);
    endtask

    task automatic send_preamble(input int period);
        for (int i = 0; i < 15; i++) send_nib(1'b1, 4'h5, period);
        send_nib(1'b1, 4'hD, period);
    endtask

    task automatic send_idle(input int n, input int period);
        for (int i = 0; i < n; i++) send_nib(1'b0, 4'h0, period);
    endtask

    task automatic send_bytes(input int first, input int stop, input int period);
        logic [7:0] b;
        for (int i = first; i < stop; i++) begin
            b = frm[i];
            send_byte(b, period);
        end
    endtask

    task automatic send_frame(input int period);
        send_preamble(period);
        send_bytes(0, frm.size(), period);
    endtask

    // ---------------- frame construction ------------------------------------
    task automatic build_frame(input int n);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'(i));
    endtask

    task automatic append_fcs();
        logic [31:0] c;
        logic [7:0]  d;
        c = 32'hFFFF_FFFF;
        foreach (frm[k]) begin
            d = frm[k];
            for (int i = 0; i < 8; i++) begin
                if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB8_8320;
                else             c = c >> 1;
            end
        end
        c = ~c;
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24]);
    endtask

    // Expect the first n bytes of frm; the n-th carries last/err/fcs_ok.
    task automatic expect_bytes(input int n, input logic has_last,
                                input logic err, input logic fcs_ok);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = frm[i];
            if (has_last && i == n - 1) exp_q.push_back({1'b1, err, fcs_ok, d});
            else                        exp_q.push_back({3'b000, d});
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge phy_smii_ref_clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_counts(input string name, input logic [15:0] ok, input logic [15:0] err);
        check({name, "_ok_cnt"}, frame_ok_cnt, ok);
        check({name, "_err_cnt"}, frame_err_cnt, err);
        check({name, "_state_idle"}, dbg_state, 2'd0);
    endtask

    // ---------------- scoreboard monitor ------------------------------------
    logic rxc_prev = 1'b0;
    logic smp_edge = 1'b0;

    always @(posedge phy_smii_ref_clk) begin
        smp_edge = mac_mii_rxc & ~rxc_prev;
        rxc_prev = mac_mii_rxc;
    end

    always @(negedge phy_smii_ref_clk) begin
        logic [10:0] exp;
        if (out_valid) begin
            tests_run++;
            if (!smp_edge) begin
                tests_failed++;
                $display("FAIL strobe_timing: out_valid with no rxc rise at the previous edge, got 0, required 1");
            end
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_strobe: got data 0x%0h last %0b err %0b fcs %0b, required no strobe",
                         out_data, out_last, out_err, out_fcs_ok);
            end else begin
                exp = exp_q.pop_front();
                if ({out_last, out_err, out_fcs_ok, out_data} !== exp) begin
                    tests_failed++;
                    $display("FAIL byte_out: got {last,err,fcs,data}=%b_%b_%b_%h, required %b_%b_%b_%h",
                             out_last, out_err, out_fcs_ok, out_data,
                             exp[10], exp[9], exp[8], exp[7:0]);
                end
            end
        end else begin
            tests_run++;
            if ({out_last, out_err, out_fcs_ok} !== 3'b000) begin
                tests_failed++;
                $display("FAIL idle_qualifiers: got {last,err,fcs}=%b, required 000",
                         {out_last, out_err, out_fcs_ok});
            end
        end
    end

    // ---------------- stimulus ----------------------------------------------
    initial begin
        repeat (5) @(negedge phy_smii_ref_clk);
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check_counts("reset", 16'd0, 16'd0);
        rstn_async = 1'b1;
        send_idle(2, P100);

        // Good 64-byte frame at 100M.
        build_frame(60);
        append_fcs();
        expect_bytes(64, 1'b1, 1'b0, 1'b1);
        send_frame(P100);
        send_idle(4, P100);
        wait_drain("good100_drain");
        check_counts("good100", 16'd1, 16'd0);

        // Single bit flipped in payload, FCS left from the original.
        frm[10] = frm[10] ^ 8'h04;
        expect_bytes(64, 1'b1, 1'b1, 1'b0);
        send_frame(P100);
        send_idle(4, P100);
        wait_drain("badfcs_drain");
        check_counts("badfcs", 16'd1, 16'd1);

        // Same good frame at 10M timing.
        build_frame(60);
        append_fcs();
        expect_bytes(64, 1'b1, 1'b0, 1'b1);
        send_frame(P10);
        send_idle(4, P10);
        wait_drain("good10_drain");
        check_counts("good10", 16'd2, 16'd1);

        // Extra nibble after the FCS.
        expect_bytes(64, 1'b1, 1'b1, 1'b1);
        send_frame(P100);
        send_nib(1'b1, 4'hA, P100);
        send_idle(4, P100);
        wait_drain("oddnib_drain");
        check_counts("oddnib", 16'd2, 16'd2);

        // Preamble error: 0x55 0x57 ... produces nothing.
        send_nib(1'b1, 4'h5, P100);
        send_nib(1'b1, 4'h5, P100);
        send_nib(1'b1, 4'h7, P100);
        send_nib(1'b1, 4'h5, P100);
        for (int i = 0; i < 11; i++) send_nib(1'b1, 4'h5, P100);
        send_nib(1'b1, 4'hD, P100);
        send_bytes(0, 10, P100);
        send_idle(4, P100);
        wait_drain("preerr_drain");
        check_counts("preerr", 16'd2, 16'd2);

        // 30-byte runt with a valid FCS.
        build_frame(26);
        append_fcs();
        expect_bytes(30, 1'b1, 1'b1, 1'b1);
        send_frame(P100);
        send_idle(4, P100);
        wait_drain("runt_drain");
        check_counts("runt", 16'd2, 16'd3);

        // 1600-byte frame: truncated at strobe 1522.
        build_frame(1600);
        expect_bytes(1522, 1'b1, 1'b1, 1'b0);
        send_frame(P100);
        send_idle(4, P100);
        wait_drain("trunc_drain");
        check_counts("trunc", 16'd2, 16'd4);

        // Reset in the middle of a frame after four bytes have come out.
        build_frame(60);
        append_fcs();
        expect_bytes(4, 1'b0, 1'b0, 1'b0);
        send_preamble(P100);
        send_bytes(0, 5, P100);
        wait_drain("prereset_drain");
        @(negedge phy_smii_ref_clk);
        rstn_async = 1'b0;
        repeat (3) @(negedge phy_smii_ref_clk);
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);
        check("midrst_flags", {out_last, out_err, out_fcs_ok}, 0);
        check_counts("midrst", 16'd0, 16'd0);
        rstn_async = 1'b1;
        // Rest of the interrupted frame must be ignored.
        send_bytes(5, 60, P100);
        send_idle(4, P100);
        wait_drain("postrst_tail_drain");
        check_counts("postrst_tail", 16'd0, 16'd0);

        // Next good frame received normally.
        expect_bytes(64, 1'b1, 1'b0, 1'b1);
        send_frame(P100);
        send_idle(4, P100);
        wait_drain("postrst_good_drain");
        check_counts("postrst_good", 16'd1, 16'd0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
